// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file and its debug dump engine.
package reg_file_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/reg_dump_fsm.sv
// Sequential dump engine: walks every register index once and presents one entry per cycle.
module reg_dump_fsm
  import reg_file_pkg::*;
#(
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] scan_addr,
  output logic                 scan_en,
  output logic                 valid,
  output logic [ADDR_BITS-1:0] idx_out,
  output logic                 done,
  output logic                 busy
);

  dump_state_t          state, state_nx;
  logic [ADDR_BITS-1:0] idx, idx_nx;
  logic [ADDR_BITS-1:0] idx_out_nx;
  logic                 valid_nx;
  logic                 done_nx;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      idx     <= '0;
      valid   <= 1'b0;
      idx_out <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      valid   <= valid_nx;
      idx_out <= idx_out_nx;
      done    <= done_nx;
    end
  end

  // The last index parks the scan in DONE rather than wrapping into a second pass.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    valid_nx   = valid;
    idx_out_nx = idx_out;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        if (start) begin
          state_nx = SCAN;
          idx_nx   = '0;
        end
      end
      SCAN: begin
        valid_nx   = 1'b1;
        idx_out_nx = idx;
        if (idx == {ADDR_BITS{1'b1}}) begin
          state_nx = DONE;
        end else begin
          idx_nx = idx + ADDR_BITS'(1);
        end
      end
      DONE: begin
        valid_nx = 1'b0;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  assign scan_addr = idx;
  assign scan_en   = (state == SCAN);
  assign busy      = (state != IDLE) || done;

endmodule

// File: rtl/reg_file.sv
// 32-entry MIPS register file: two combinational read ports, one write port, optional write bypass, debug dump.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADDR_BITS-1:0] RA1,
  input  logic [ADDR_BITS-1:0] RA2,
  output logic [WIDTH-1:0]     RD1,
  output logic [WIDTH-1:0]     RD2,
  input  logic                 WE,
  input  logic [ADDR_BITS-1:0] WA,
  input  logic [WIDTH-1:0]     WD,
  input  logic                 DumpStart,
  output logic                 DumpBusy,
  output logic                 DumpValid,
  output logic [ADDR_BITS-1:0] DumpIdx,
  output logic [WIDTH-1:0]     DumpData,
  output logic                 DumpDone
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ZERO_ADDR = ADDR_BITS'(REG_ZERO);

  logic [WIDTH-1:0]     regs [DEPTH];
  logic [ADDR_BITS-1:0] scan_addr;
  logic                 scan_en;
  logic                 wr_ok;

  assign wr_ok = WE && (WA != ZERO_ADDR);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[WA] <= WD;
    end
  end

  // Register 0 reads as zero no matter what; bypass only applies to real registers.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (RA1 != ZERO_ADDR) begin
      RD1 = regs[RA1];
      if ((BYPASS != 0) && wr_ok && (WA == RA1)) begin
        RD1 = WD;
      end
    end
    if (RA2 != ZERO_ADDR) begin
      RD2 = regs[RA2];
      if ((BYPASS != 0) && wr_ok && (WA == RA2)) begin
        RD2 = WD;
      end
    end
  end

  // Dump data is the stored value at the scan edge, so a coincident write is seen only afterwards.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      DumpData <= '0;
    end else if (scan_en) begin
      DumpData <= regs[scan_addr];
    end
  end

  reg_dump_fsm #(
    .ADDR_BITS(ADDR_BITS)
  ) u_dump (
    .clk      (clk),
    .rstn     (rstn),
    .start    (DumpStart),
    .scan_addr(scan_addr),
    .scan_en  (scan_en),
    .valid    (DumpValid),
    .idx_out  (DumpIdx),
    .done     (DumpDone),
    .busy     (DumpBusy)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: directed read/write/bypass checks plus a queued dump-stream monitor.
module tb_reg_file;
  import reg_file_pkg::*;

  logic        clk;
  logic        rstn;
  logic [4:0]  RA1, RA2, WA;
  logic [31:0] WD;
  logic        WE;
  logic        DumpStart;

  logic [31:0] RD1, RD2, DumpData;
  logic        DumpBusy, DumpValid, DumpDone;
  logic [4:0]  DumpIdx;

  logic [31:0] nbRD1, nbRD2, nbDumpData;
  logic        nbDumpBusy, nbDumpValid, nbDumpDone;
  logic [4:0]  nbDumpIdx;

  int vectors;
  int miscompares;

  typedef struct {
    bit          isDone;
    logic [4:0]  idx;
    logic [31:0] data;
  } dumpExp_t;

  dumpExp_t expQ[$];

  reg_file #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(1)) dut (
    .clk(clk), .rstn(rstn), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .WE(WE), .WA(WA), .WD(WD), .DumpStart(DumpStart), .DumpBusy(DumpBusy),
    .DumpValid(DumpValid), .DumpIdx(DumpIdx), .DumpData(DumpData), .DumpDone(DumpDone)
  );

  reg_file #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(0)) dutNoBypass (
    .clk(clk), .rstn(rstn), .RA1(RA1), .RA2(RA2), .RD1(nbRD1), .RD2(nbRD2),
    .WE(WE), .WA(WA), .WD(WD), .DumpStart(DumpStart), .DumpBusy(nbDumpBusy),
    .DumpValid(nbDumpValid), .DumpIdx(nbDumpIdx), .DumpData(nbDumpData), .DumpDone(nbDumpDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra1, input logic [4:0] ra2, input logic start);
    WE = we; WA = wa; WD = wd; RA1 = ra1; RA2 = ra2; DumpStart = start;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushDump(input int lastIdx, input bit withDone, input logic [31:0] r3Val);
    dumpExp_t e;
    for (int i = 0; i <= lastIdx; i++) begin
      e.isDone = 1'b0;
      e.idx    = 5'(i);
      e.data   = (i == 3) ? r3Val : 32'(i * 4);
      expQ.push_back(e);
    end
    if (withDone) begin
      e.isDone = 1'b1;
      e.idx    = '0;
      e.data   = '0;
      expQ.push_back(e);
    end
  endtask

  // Monitor: every presented dump entry or done pulse must match the head of the queue.
  always @(negedge clk) begin
    dumpExp_t e;
    if (DumpValid === 1'b1) begin
      if (expQ.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL unexpected_valid: got idx %0d data %h expected no entry", DumpIdx, DumpData);
      end else begin
        e = expQ.pop_front();
        checkOutput("dump_kind_valid", {31'd0, e.isDone}, 32'd0);
        checkOutput("dump_idx", {27'd0, DumpIdx}, {27'd0, e.idx});
        checkOutput("dump_data", DumpData, e.data);
      end
    end
    if (DumpDone === 1'b1) begin
      if (expQ.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL unexpected_done: got DumpDone=1 expected 0");
      end else begin
        e = expQ.pop_front();
        checkOutput("dump_kind_done", {31'd0, e.isDone}, 32'd1);
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;

    // Reset while a write to r5 is being presented.
    rstn = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", {31'd0, DumpValid}, 32'd0);
    checkOutput("rst_done", {31'd0, DumpDone}, 32'd0);
    checkOutput("rst_busy", {31'd0, DumpBusy}, 32'd0);
    checkOutput("rst_idx", {27'd0, DumpIdx}, 32'd0);
    checkOutput("rst_data", DumpData, 32'd0);
    rstn = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0);
    #1;
    checkOutput("rst_r5", RD1, 32'd0);
    tick();
    checkOutput("rst_r5_after_edge", RD1, 32'd0);

    // Write r8 then attempt r0.
    applyStimulus(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 1'b0);
    #1;
    checkOutput("rd_r8", RD1, 32'hDEAD_BEEF);
    checkOutput("rd_r0", RD2, 32'd0);
    checkOutput("nb_rd_r8", nbRD1, 32'hDEAD_BEEF);

    // Bypass of r9 on both ports, then write to r0 with bypass.
    applyStimulus(1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 1'b0);
    #1;
    checkOutput("byp_rd1", RD1, 32'hA5A5_A5A5);
    checkOutput("byp_rd2", RD2, 32'hA5A5_A5A5);
    checkOutput("nobyp_rd1", nbRD1, 32'd0);
    checkOutput("nobyp_rd2", nbRD2, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0);
    #1;
    checkOutput("r9_stored", RD1, 32'hA5A5_A5A5);
    checkOutput("nb_r9_stored", nbRD2, 32'hA5A5_A5A5);
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0);
    #1;
    checkOutput("byp_r0", RD1, 32'd0);
    tick();

    // Preload r[i] = i*4.
    for (int i = 1; i < NUM_REGS; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i * 4), 5'd0, 5'd0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd31, 5'd17, 1'b0);
    #1;
    checkOutput("pre_r31", RD1, 32'd124);
    checkOutput("pre_r17", RD2, 32'd68);

    // Full dump with single-cycle start pulse.
    pushDump(31, 1'b1, 32'd12);
    DumpStart = 1'b1;
    tick();
    DumpStart = 1'b0;
    checkOutput("busy_start", {31'd0, DumpBusy}, 32'd1);
    for (int k = 1; k <= 33; k++) begin
      tick();
      checkOutput("busy_scan", {31'd0, DumpBusy}, 32'd1);
    end
    tick();
    checkOutput("busy_end", {31'd0, DumpBusy}, 32'd0);
    checkOutput("queue_empty_1", 32'(expQ.size()), 32'd0);

    // Start held through part of the scan, with a write to r3 at its scan edge.
    pushDump(31, 1'b1, 32'd12);
    DumpStart = 1'b1;
    tick();
    for (int k = 1; k <= 33; k++) begin
      WE = (k == 4);
      WA = 5'd3;
      WD = 32'h0000_CAFE;
      DumpStart = (k < 10);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b0);
    tick();
    checkOutput("busy_end_2", {31'd0, DumpBusy}, 32'd0);
    checkOutput("queue_empty_2", 32'(expQ.size()), 32'd0);
    checkOutput("r3_new", RD1, 32'h0000_CAFE);

    // Reset while idx 10 is being presented aborts the dump.
    pushDump(10, 1'b0, 32'h0000_CAFE);
    DumpStart = 1'b1;
    tick();
    DumpStart = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
    end
    checkOutput("pre_abort_idx", {27'd0, DumpIdx}, 32'd10);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checkOutput("abort_valid", {31'd0, DumpValid}, 32'd0);
    checkOutput("abort_done", {31'd0, DumpDone}, 32'd0);
    checkOutput("abort_busy", {31'd0, DumpBusy}, 32'd0);
    checkOutput("abort_idx", {27'd0, DumpIdx}, 32'd0);
    checkOutput("abort_data", DumpData, 32'd0);
    for (int k = 0; k < 40; k++) begin
      tick();
    end
    checkOutput("abort_idle", {31'd0, DumpBusy}, 32'd0);
    checkOutput("queue_empty_3", 32'(expQ.size()), 32'd0);
    checkOutput("abort_r3_cleared", RD1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath.
- Sits directly downstream of the write-back select mux (ALU result / memory data / PC+4) and the destination-register select mux, and consumes their outputs as write data and write address.
- Provides two asynchronous read ports for the ALU operand path.
- Includes a sequential debug dump engine that streams all registers out, one per cycle, for the board display and the testbench.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_BITS, 5, register address width; depth is 2**ADDR_BITS.
- BYPASS, 1, 1 = a same-cycle write to the addressed register is forwarded to the read ports; 0 = read ports return stored contents only.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  synchronous active-low reset.
- RA1  in  ADDR_BITS  read address, port 1 (rs).
- RA2  in  ADDR_BITS  read address, port 2 (rt).
- RD1  out  WIDTH  read data, port 1, combinational.
- RD2  out  WIDTH  read data, port 2, combinational.
- WE  in  1  write enable.
- WA  in  ADDR_BITS  write address, from the destination-register mux.
- WD  in  WIDTH  write data, from the write-back mux.
- DumpStart  in  1  request a full register dump; single-cycle pulse or level.
- DumpBusy  out  1  high from the cycle after an accepted start until DumpDone deasserts.
- DumpValid  out  1  DumpIdx/DumpData valid this cycle.
- DumpIdx  out  ADDR_BITS  index of the register being presented.
- DumpData  out  WIDTH  contents of register DumpIdx.
- DumpDone  out  1  one-cycle pulse after the last entry.

Behaviour:
- Reset: clk and rstn only; the reset is synchronous and active-low. At a rising edge with rstn=0:
  - all registers are cleared to 0;
  - the FSM goes to IDLE and the scan index to 0;
  - DumpValid, DumpDone, DumpBusy, DumpIdx and DumpData are driven to 0.
  - Reset asserted mid-dump aborts the dump: no DumpDone is produced.
- Register 0 is hardwired:
  - reads of address 0 always return 0;
  - writes to WA=0 are discarded, including through bypass.
- Write: at a rising edge with WE=1 and WA!=0, reg[WA] <= WD. The write is visible on the read ports the following cycle.
- Read: RDn = reg[RAn] combinationally.
  - If BYPASS=1, WE=1, WA=RAn and RAn!=0, then RDn = WD in the same cycle.
  - RA1=RA2 is legal; both ports return identical data.
- Dump FSM (states IDLE, SCAN, DONE):
  - IDLE: at an edge with DumpStart=1 -> SCAN, idx<=0. DumpStart in any other state is ignored.
  - SCAN: each edge registers DumpValid<=1, DumpIdx<=idx and DumpData<=reg[idx] (stored value; bypass is not applied), then idx<=idx+1. When idx=31 -> DONE. idx does not wrap into a second pass.
  - DONE: one edge sets DumpValid<=0 and DumpDone<=1, then -> IDLE. At the next edge DumpDone<=0.
  - Timing: start sampled at edge N gives DumpValid high for exactly 32 consecutive cycles (after edges N+1..N+32), with DumpIdx 0..31, and DumpDone high for one cycle after edge N+33.
  - A write at the same edge as the scan of that register: DumpData shows the old value. Writes proceed normally during a dump.
  - DumpBusy = (state != IDLE) || DumpDone.
- Widths: no arithmetic beyond the ADDR_BITS-wide idx increment. Terminal detection uses idx == 2**ADDR_BITS-1.

Decomposition:
- Shared package/header: NUM_REGS, REG_ZERO (0), and the dump state encodings IDLE/SCAN/DONE (2 bits).
- One natural sub-module, reg_dump_fsm. It owns the state, idx, DumpValid, DumpIdx, DumpDone and DumpBusy, and emits a scan address that the top uses to index the array.
- The storage array and the read/bypass logic stay in reg_file.

Test Plan:
- Reset: hold rstn=0 for 2 edges with WE=1, WA=5, WD=32'hFFFF_FFFF -> RD1 for RA1=5 reads 0 after reset releases; all dump outputs are 0.
- Write/read and $0: write 32'hDEAD_BEEF to r8, then 32'h1234 to r0 -> RA1=8 reads 32'hDEAD_BEEF; RA2=0 reads 0.
- Bypass: WE=1, WA=RA1=9, WD=32'hA5A5_A5A5 with old r9=0 -> RD1=32'hA5A5_A5A5 in the same cycle with BYPASS=1, 0 with BYPASS=0. With WA=0 and RA1=0, RD1=0.
- Full dump: preload r[i]=i*4, pulse DumpStart -> 32 consecutive DumpValid cycles with DumpIdx 0..31 and DumpData 0,4,...,124; then a one-cycle DumpDone; DumpBusy high throughout.
- Dump corner cases:
  - DumpStart held high during SCAN -> no restart;
  - a write to r3 at the edge scanning r3 -> old value streamed, new value readable afterwards;
  - rstn=0 at DumpIdx=10 -> DumpValid=0, no DumpDone, FSM in IDLE.
